// File: rtl/updown_seg_display_pkg.sv
// Shared constants for the two-digit up/down counter display: active-low
// segment codes, active-low anode patterns, digit-slot encoding, BCD split helpers.
package updown_seg_pkg;

    // Segment order {g,f,e,d,c,b,a}; a 0 lights the segment.
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [1:0] AN_OFF  = 2'b11;
    localparam logic [1:0] AN_ONES = 2'b10;
    localparam logic [1:0] AN_TENS = 2'b01;

    localparam logic [0:0] DIG0 = 1'b0;
    localparam logic [0:0] DIG1 = 1'b1;

    function automatic logic [1:0] tens_of(input logic [4:0] v);
        if (v >= 5'd30)      return 2'd3;
        else if (v >= 5'd20) return 2'd2;
        else if (v >= 5'd10) return 2'd1;
        else                 return 2'd0;
    endfunction

    function automatic logic [3:0] ones_of(input logic [4:0] v, input logic [1:0] t);
        return 4'(v - 5'(t) * 5'd10);
    endfunction

endpackage

// File: rtl/updown_seg_display_seg7_decode.sv
// BCD nibble to active-low seven-segment code; nibbles 10..15 blank the digit.
module seg7_decode
    import updown_seg_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/updown_seg_display.sv
// Two-digit multiplexed seven-segment display of a 5-bit counter value, sampled once per frame.
// Optional leading-zero blanking of the tens digit: define UPDOWN_SEG_LZB_EN.
module updown_seg_display
    import updown_seg_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] count,
    input  logic       disp_en,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       frame
);

    localparam int unsigned CW = $clog2(REFRESH_DIV);

    logic [CW-1:0] cnt;
    logic [0:0]    state;
    logic [4:0]    shadow;
    logic [1:0]    tens;
    logic [3:0]    ones;
    logic          slot_end;
    logic          frame_end;
    logic [3:0]    digit;
    logic [6:0]    seg_dec;
    logic [1:0]    an_next;
    logic [6:0]    seg_next;

    // Digits are derived from the frame-captured value, so they only move at frame end.
    assign tens      = tens_of(shadow);
    assign ones      = ones_of(shadow, tens);
    assign slot_end  = (cnt == CW'(REFRESH_DIV - 1));
    assign frame_end = disp_en && slot_end && (state == DIG1);
    assign digit     = (state == DIG0) ? ones : {2'b00, tens};

    seg7_decode u_dec (
        .bcd (digit),
        .seg (seg_dec)
    );

    always_comb begin
        an_next = AN_OFF;
        if (disp_en && (cnt != '0)) begin
            an_next = (state == DIG0) ? AN_ONES : AN_TENS;
`ifdef UPDOWN_SEG_LZB_EN
            if ((state == DIG1) && (tens == 2'd0))
                an_next = AN_OFF;
`endif
        end
        seg_next = (an_next == AN_OFF) ? SEG_BLANK : seg_dec;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            state  <= DIG0;
            shadow <= '0;
            frame  <= 1'b0;
            an     <= AN_OFF;
            seg    <= SEG_BLANK;
        end else begin
            an    <= an_next;
            seg   <= seg_next;
            frame <= frame_end;
            if (disp_en) begin
                if (slot_end) begin
                    cnt   <= '0;
                    state <= ~state;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
            if (frame_end)
                shadow <= count;
        end
    end

endmodule

// File: tb/tb_updown_seg_display.sv
// Scoreboard bench for updown_seg_display (REFRESH_DIV=4); honours UPDOWN_SEG_LZB_EN if defined.
module tb_updown_seg_display;

    localparam int unsigned RD    = 4;
    localparam int unsigned FRAME = 2 * RD;

    typedef struct packed {
        logic [1:0] an;
        logic [6:0] seg;
        logic       frame;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [4:0] count = '0;
    logic       disp_en = 1'b0;
    logic [6:0] seg;
    logic [1:0] an;
    logic       frame;

    int          checks = 0;
    int          errors = 0;
    exp_t        q[$];
    string       phase = "init";
    int unsigned pos = 0;
    logic [4:0]  shown = '0;
    logic [6:0]  segtab [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                  7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    always #5 clk = ~clk;

    updown_seg_display #(.REFRESH_DIV(RD)) dut (
        .clk     (clk),
        .reset   (reset),
        .count   (count),
        .disp_en (disp_en),
        .seg     (seg),
        .an      (an),
        .frame   (frame)
    );

    task automatic compare(input string name, input exp_t act, input exp_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got an=%b seg=%h frame=%b, expected an=%b seg=%h frame=%b",
                     name, $time, act.an, act.seg, act.frame, exp.an, exp.seg, exp.frame);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            compare(phase, {an, seg, frame}, e);
        end
    end

    // One clock of stimulus: push what the outputs must be after the coming edge.
    task automatic step();
        exp_t        e;
        int unsigned t;
        int unsigned o;
        t = int'(shown) / 10;
        o = int'(shown) % 10;
        e.an    = 2'b11;
        e.seg   = 7'h7F;
        e.frame = disp_en && (pos == FRAME - 1);
        if (disp_en && (pos % RD) != 0) begin
            if (pos < RD) begin
                e.an  = 2'b10;
                e.seg = segtab[o];
            end else begin
`ifdef UPDOWN_SEG_LZB_EN
                if (t != 0) begin
                    e.an  = 2'b01;
                    e.seg = segtab[t];
                end
`else
                e.an  = 2'b01;
                e.seg = segtab[t];
`endif
            end
        end
        if (disp_en) begin
            if (pos == FRAME - 1)
                shown = count;
            pos = (pos + 1) % FRAME;
        end
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input string name);
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        compare(name, {an, seg, frame}, {2'b11, 7'h7F, 1'b0});
        q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        reset = 1'b0;
        pos   = 0;
        shown = '0;
    endtask

    initial begin
        #1;
        reset = 1'b1;
        #1;
        compare("reset_init", {an, seg, frame}, {2'b11, 7'h7F, 1'b0});
        @(negedge clk);
        #1;
        reset = 1'b0;

        phase = "count23";
        count = 5'd23;
        disp_en = 1'b1;
        repeat (3 * FRAME) step();

        phase = "count31";
        count = 5'd31;
        repeat (2 * FRAME + 3) step();

        // Mid-frame async reset with a nonzero value captured.
        apply_reset("reset_midrun");
        phase = "post_reset";
        repeat (3 * FRAME) step();

        phase = "count0";
        count = 5'd0;
        repeat (3 * FRAME) step();

        phase = "count12_13";
        count = 5'd12;
        for (int i = 0; i < 40 && !(shown == 5'd12 && pos == RD + 1); i++) step();
        checks++;
        if (!(shown == 5'd12 && pos == RD + 1)) begin
            errors++;
            $display("FAIL sync_dig1: pos=%0d shown=%0d, required pos=%0d shown=12", pos, shown, RD + 1);
        end
        count = 5'd13;
        repeat (2 * FRAME) step();

        phase = "disp_en_pause";
        for (int i = 0; i < 2 * FRAME && pos != 2; i++) step();
        disp_en = 1'b0;
        repeat (5) step();
        disp_en = 1'b1;
        repeat (3 * FRAME) step();

        phase = "sweep";
        for (int v = 0; v < 32; v++) begin
            count = 5'(v);
            repeat (FRAME) step();
        end
        repeat (FRAME) step();

        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, required 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/updown_seg_display.md
Name: updown_seg_display

Overview:
- Downstream consumer of the 5-bit up/down counter value.
- Converts `count` (0..31) to two BCD digits and drives a time-multiplexed, active-low, two-digit seven-segment display.
- Samples the count once per display frame so a digit never changes mid-scan (no tearing).
- Has an anti-ghosting blank cycle at the start of each digit slot.

Parameters:
- REFRESH_DIV, 16: clock cycles per digit slot. Must be ≥ 2. One frame = 2*REFRESH_DIV cycles.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- count  input  5  unsigned counter value, 0..31.
- disp_en  input  1  display enable. 0 freezes the scan and blanks the display.
- seg  output  7  {g,f,e,d,c,b,a}, active-low.
- an  output  2  digit anodes, active-low. an[0] = ones, an[1] = tens.
- frame  output  1  one-cycle pulse when a new count is captured.

Behaviour:
- Reset (async, immediate):
  - Outputs: an=2'b11, seg=7'h7F, frame=0.
  - Internal: prescaler cnt=0, digit state=DIG0, shadow=0.
- State machine has two states:
  - DIG0 shows the ones digit; DIG1 shows the tens digit.
  - When disp_en=1, cnt increments every cycle.
  - When cnt==REFRESH_DIV-1, cnt wraps to 0 and the state toggles DIG0↔DIG1.
- Frame end is the cycle where cnt==REFRESH_DIV-1, state==DIG1 and disp_en=1. On that cycle:
  - shadow <= count;
  - tens <= 3/2/1/0 for count ≥30/≥20/≥10/else;
  - ones <= count − 10*tens;
  - frame=1 for that single cycle. This is a registered output, so it is visible in the cycle after the frame-end condition.
- Outputs are registered with 1-cycle latency: an/seg at cycle t+1 are derived from (state, cnt, tens, ones) at cycle t.
- Anode rules:
  - Slot position cnt==0: an=2'b11 (anti-ghost blank).
  - cnt 1..REFRESH_DIV-1: an=2'b10 in DIG0, 2'b01 in DIG1.
- Segment rules:
  - seg = decode(ones) in DIG0, decode(tens) in DIG1.
  - seg=7'h7F whenever an=2'b11.
- disp_en=0:
  - cnt and state hold; shadow holds; frame=0.
  - an=2'b11 and seg=7'h7F from the next cycle.
  - When disp_en returns to 1, the scan resumes from the held position.
- All 32 count values are legal. No overflow is possible: tens ≤ 3, ones ≤ 9.
- Count changes between frame ends are ignored until the next frame end.
- After reset release, the display shows "00" until the first frame end, which occurs 2*REFRESH_DIV cycles after release.
- Reset mid-frame: immediate return to the reset state; shadow is cleared to 0.

Optional Feature:
- Macro UPDOWN_SEG_LZB_EN (leading-zero blanking).
- Defined: in DIG1, when tens==0, an=2'b11 and seg=7'h7F for the whole slot. The DIG0 slot is unaffected.
- Undefined: tens==0 displays "0" (seg=7'h40).

Decomposition:
- Package updown_seg_pkg:
  - segment code constants SEG_0..SEG_9 and SEG_BLANK=7'h7F;
  - anode constants AN_OFF=2'b11, AN_ONES=2'b10, AN_TENS=2'b01;
  - digit state encoding DIG0/DIG1.
- One combinational sub-module, seg7_decode: 4-bit BCD in, 7-bit active-low segments out. Nibble values 10..15 map to SEG_BLANK.

Test Plan (REFRESH_DIV=4, 8-cycle frame):
1. Assert reset mid-run, asynchronously between clock edges → an=2'b11, seg=7'h7F, frame=0 immediately. After release, the first frame pulse arrives after 8 cycles.
2. Hold count=23, disp_en=1, then wait past one frame pulse → per frame, an sequence is 11,10,10,10,11,01,01,01. seg=7'h30 ("3") during an=10 and 7'h24 ("2") during an=01.
3. count=31 → ones slot shows 7'h79 ("1"), tens slot shows 7'h30 ("3").
   count=0 → both slots show 7'h40. With UPDOWN_SEG_LZB_EN defined, the tens slot is an=11, seg=7'h7F.
4. Change count 12→13 while in the DIG1 slot before frame end → display stays "12" until the frame pulse, then shows "13". Exactly one frame pulse per 8 cycles.
5. Drop disp_en for 5 cycles at cnt=2 in DIG0 → from the next cycle an=11, seg=7'h7F, frame=0. After re-enable, the scan continues from cnt=2, DIG0, and the frame period is extended by exactly 5 cycles.
